player_motion: RTL and testbench
================================

PLAYER_MOTION -- requirements
Module: player_motion

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  X_START, 64, reset x position in pixels
  X_MAX, 608, rightmost legal x (640 minus 32-pixel sprite width)
  FLOOR_Y, 362, ground y (floor line 394 minus 32-pixel sprite height)
  WALK_STEP, 2, horizontal pixels moved per frame tick
  JUMP_V0, 12, launch speed in pixels per frame
  VMAX, 12, fall-speed clamp in pixels per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  pixel clock, sole clock
  rst_l  input  1  asynchronous active-low reset
  frame_tick  input  1  single-cycle pulse, once per frame, during vertical blanking
  btn_left  input  1  raw, asynchronous move-left button
  btn_right  input  1  raw, asynchronous move-right button
  btn_jump  input  1  raw, asynchronous jump button
  player_x  output  10  sprite top-left x, registered
  player_y  output  10  sprite top-left y, registered
  airborne  output  1  high when FSM is not GROUND
  facing_left  output  1  last horizontal direction moved; 1 = left

Function
REQ-003 Every button SHALL pass a two-flop synchronizer on clk before any use.
REQ-004 State, position and velocity SHALL update only on clk edges where frame_tick=1; outputs SHALL show the new values on the cycle after that edge and hold otherwise.
REQ-005 Horizontal, left only: x <= (x < WALK_STEP) ? 0 : x-WALK_STEP, facing_left <= 1.
REQ-006 Horizontal, right only: x <= (x+WALK_STEP > X_MAX) ? X_MAX : x+WALK_STEP, facing_left <= 0; arithmetic in 11 bits, no wrap.
REQ-007 Left and right together, or neither: x and facing_left SHALL hold.
REQ-008 Jump SHALL be a rising edge of the synchronized jump level between consecutive frame ticks; edges seen while airborne SHALL be discarded, not queued.
REQ-009 FSM states SHALL be GROUND, RISE, FALL; vy SHALL be a 5-bit unsigned speed, with direction implied by state.
REQ-010 GROUND on a jump edge: go to RISE, vy <= JUMP_V0, y held.
REQ-011 RISE tick: y <= y-vy and vy <= vy-1; if vy==1, go to FALL with vy <= 0.
REQ-012 FALL tick: compute vn = min(vy+1, VMAX) and yn = y+vn; if yn >= FLOOR_Y then y <= FLOOR_Y, vy <= 0, go to GROUND; else y <= yn, vy <= vn.
REQ-013 Horizontal movement SHALL apply in all states, in the same tick as the vertical update.
REQ-014 With default parameters, a jump SHALL rise 78 pixels (apex y=284) over 12 RISE ticks, then land exactly at y=362 after 12 FALL ticks.

Reset
REQ-015 With rst_l=0, asynchronously: player_x=X_START, player_y=FLOOR_Y, state GROUND, vy=0, airborne=0, facing_left=0, synchronizers and previous-jump sample cleared.
REQ-016 Reset asserted mid-jump SHALL abort the jump immediately; after release, the first tick SHALL behave as a tick in GROUND.

Configuration
REQ-017 Macro PLAYER_DEBOUNCE_EN defined: each synchronized button SHALL count as changed only after its new level matches on 2 consecutive frame ticks, adding one frame of latency.
REQ-018 Macro PLAYER_DEBOUNCE_EN undefined: the synchronized level sampled at each frame tick SHALL be used directly, with no debounce logic.

Verification
REQ-019 Reset, then no buttons for 5 ticks -> x=64, y=362, airborne=0, facing_left=0.
REQ-020 Reset, right held 400 ticks -> x rises 2 per tick and saturates at 608; left held 400 ticks -> x=0, facing_left=1.
REQ-021 Jump pulsed at tick 0 -> airborne=1 from tick 0, y=284 after tick 12, y=362 and airborne=0 after tick 24.
REQ-022 Jump held continuously through landing -> exactly one jump; a second jump needs release and re-press.
REQ-023 Reset asserted at tick 6 of a jump -> y=362 and airborne=0 immediately, before the next clk edge.
REQ-024 Jump plus right for 24 ticks from x=100 -> x=148 at landing; left+right together -> x unchanged.

Source files
------------

// File: rtl/player_motion.sv
// Frame-rate player sprite motion: walk left/right with clamping, jump/fall FSM with gravity.
// Optional macro PLAYER_DEBOUNCE_EN adds a two-frame-tick debounce on each synchronized button.
module player_motion #(
  parameter int X_START   = 64,
  parameter int X_MAX     = 608,
  parameter int FLOOR_Y   = 362,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V0   = 12,
  parameter int VMAX      = 12
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       airborne,
  output logic       facing_left
);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  localparam logic [9:0]  X_START_W = 10'(X_START);
  localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
  localparam logic [10:0] FLOOR_W   = 11'(FLOOR_Y);
  localparam logic [9:0]  STEP_W    = 10'(WALK_STEP);
  localparam logic [4:0]  V0_W      = 5'(JUMP_V0);
  localparam logic [5:0]  VMAX_W    = 6'(VMAX);

  // Button bit order everywhere: {jump, right, left}.
  logic [2:0] sync1_q, sync2_q, btn_lvl;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {btn_jump, btn_right, btn_left};
      sync2_q <= sync1_q;
    end
  end

`ifdef PLAYER_DEBOUNCE_EN
  logic [2:0] last_q, stable_q;

  // A level is accepted only when it matches the sample taken at the previous frame tick.
  assign btn_lvl = (~(sync2_q ^ last_q) & sync2_q) | ((sync2_q ^ last_q) & stable_q);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      last_q   <= '0;
      stable_q <= '0;
    end else if (frame_tick) begin
      last_q   <= sync2_q;
      stable_q <= btn_lvl;
    end
  end
`else
  assign btn_lvl = sync2_q;
`endif

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [4:0]  vy_q, vy_d;
  logic        face_q, face_d;
  logic        jump_prev_q, jump_prev_d;
  logic        jump_edge;
  logic [10:0] x_inc, y_fall;
  logic [5:0]  vy_inc, vn;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= GROUND;
      x_q         <= X_START_W;
      y_q         <= FLOOR_W[9:0];
      vy_q        <= '0;
      face_q      <= 1'b0;
      jump_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vy_q        <= vy_d;
      face_q      <= face_d;
      jump_prev_q <= jump_prev_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    vy_d        = vy_q;
    face_d      = face_q;
    jump_prev_d = jump_prev_q;
    jump_edge   = btn_lvl[2] & ~jump_prev_q;
    x_inc       = {1'b0, x_q} + {1'b0, STEP_W};
    vy_inc      = {1'b0, vy_q} + 6'd1;
    vn          = (vy_inc > VMAX_W) ? VMAX_W : vy_inc;
    y_fall      = {1'b0, y_q} + {5'b0, vn};

    if (frame_tick) begin
      jump_prev_d = btn_lvl[2];

      if (btn_lvl[0] && !btn_lvl[1]) begin
        x_d    = (x_q < STEP_W) ? 10'd0 : x_q - STEP_W;
        face_d = 1'b1;
      end else if (btn_lvl[1] && !btn_lvl[0]) begin
        x_d    = (x_inc > X_MAX_W) ? X_MAX_W[9:0] : x_inc[9:0];
        face_d = 1'b0;
      end

      // Edges arriving in RISE/FALL simply update jump_prev and are dropped.
      unique case (state_q)
        GROUND: begin
          if (jump_edge) begin
            state_d = RISE;
            vy_d    = V0_W;
          end
        end
        RISE: begin
          y_d = y_q - {5'b0, vy_q};
          if (vy_q == 5'd1) begin
            state_d = FALL;
            vy_d    = '0;
          end else begin
            vy_d = vy_q - 5'd1;
          end
        end
        FALL: begin
          if (y_fall >= FLOOR_W) begin
            state_d = GROUND;
            y_d     = FLOOR_W[9:0];
            vy_d    = '0;
          end else begin
            y_d  = y_fall[9:0];
            vy_d = vn[4:0];
          end
        end
        default: state_d = GROUND;
      endcase
    end
  end

  assign player_x    = x_q;
  assign player_y    = y_q;
  assign airborne    = (state_q != GROUND);
  assign facing_left = face_q;

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion (default build): a behavioural model pushes the
// expected {x, y, airborne, facing_left} per frame tick, popped after the DUT updates.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [9:0] player_x, player_y;
  logic       airborne, facing_left;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] exp_q[$];

  // Model state
  int   mx, my, mvy, mstate;  // mstate: 0 ground, 1 rise, 2 fall
  logic mface, mprev;

  player_motion dut (
    .clk(clk), .rst_l(rst_l), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .player_x(player_x), .player_y(player_y),
    .airborne(airborne), .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mx = 64; my = 362; mvy = 0; mstate = 0; mface = 1'b0; mprev = 1'b0;
  endtask

  task automatic model_step(input logic l, input logic r, input logic j);
    logic jedge;
    int vn;
    jedge = j && !mprev;
    mprev = j;
    if (l && !r) begin
      mx = (mx < 2) ? 0 : mx - 2;
      mface = 1'b1;
    end else if (r && !l) begin
      mx = (mx + 2 > 608) ? 608 : mx + 2;
      mface = 1'b0;
    end
    case (mstate)
      0: if (jedge) begin mstate = 1; mvy = 12; end
      1: begin
        my = my - mvy;
        if (mvy == 1) begin mstate = 2; mvy = 0; end
        else mvy = mvy - 1;
      end
      default: begin
        vn = (mvy + 1 > 12) ? 12 : mvy + 1;
        if (my + vn >= 362) begin my = 362; mvy = 0; mstate = 0; end
        else begin my = my + vn; mvy = vn; end
      end
    endcase
  endtask

  function automatic logic [21:0] dut_vec();
    return {player_x, player_y, airborne, facing_left};
  endfunction

  function automatic logic [21:0] model_vec();
    return {mx[9:0], my[9:0], (mstate != 0), mface};
  endfunction

  // Buttons settle through the synchronizer before the tick, then model and DUT advance together.
  task automatic do_tick(input logic l, input logic r, input logic j, input string tag);
    logic [21:0] e;
    btn_left = l; btn_right = r; btn_jump = j;
    repeat (3) @(posedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    model_step(l, r, j);
    exp_q.push_back(model_vec());
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, 32'(dut_vec()), 32'(e));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_x", 32'(player_x), 32'd64);
    check("reset_y", 32'(player_y), 32'd362);
    check("reset_air", 32'(airborne), 32'd0);
    check("reset_face", 32'(facing_left), 32'd0);
    rst_l = 1'b1;

    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0, 1'b0, "idle");
    check("idle_x", 32'(player_x), 32'd64);

    for (int i = 0; i < 400; i++) do_tick(1'b0, 1'b1, 1'b0, "right");
    check("right_sat", 32'(player_x), 32'd608);
    for (int i = 0; i < 400; i++) do_tick(1'b1, 1'b0, 1'b0, "left");
    check("left_sat", 32'(player_x), 32'd0);
    check("left_face", 32'(facing_left), 32'd1);

    for (int i = 0; i < 50; i++) do_tick(1'b0, 1'b1, 1'b0, "to100");
    check("at100", 32'(player_x), 32'd100);

    // Jump pulsed at tick 0 with right held for 24 ticks.
    do_tick(1'b0, 1'b1, 1'b1, "jump_t0");
    check("air_t0", 32'(airborne), 32'd1);
    for (int t = 1; t <= 24; t++) begin
      do_tick(1'b0, (t < 24), 1'b0, "jump_arc");
      if (t == 12) check("apex_y", 32'(player_y), 32'd284);
      if (t == 23) check("pre_land_air", 32'(airborne), 32'd1);
    end
    check("land_y", 32'(player_y), 32'd362);
    check("land_air", 32'(airborne), 32'd0);
    check("land_x", 32'(player_x), 32'd148);

    // Jump held through landing: one jump only, re-press needed.
    for (int t = 0; t < 30; t++) do_tick(1'b0, 1'b0, 1'b1, "jump_held");
    check("held_air", 32'(airborne), 32'd0);
    check("held_y", 32'(player_y), 32'd362);
    do_tick(1'b0, 1'b0, 1'b0, "release");
    do_tick(1'b0, 1'b0, 1'b1, "repress");
    check("repress_air", 32'(airborne), 32'd1);
    for (int t = 0; t < 24; t++) do_tick(1'b0, 1'b0, 1'b0, "repress_arc");
    check("repress_land", 32'(airborne), 32'd0);

    for (int t = 0; t < 4; t++) do_tick(1'b1, 1'b1, 1'b0, "both");
    check("both_x", 32'(player_x), 32'd148);

    // Reset in the middle of a jump.
    do_tick(1'b0, 1'b0, 1'b1, "mid_t0");
    for (int t = 1; t <= 6; t++) do_tick(1'b0, 1'b1, 1'b0, "mid_rise");
    check("mid_airborne", 32'(airborne), 32'd1);
    @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    model_reset();
    check("mid_rst_y", 32'(player_y), 32'd362);
    check("mid_rst_air", 32'(airborne), 32'd0);
    check("mid_rst_x", 32'(player_x), 32'd64);
    @(negedge clk);
    rst_l = 1'b1;
    do_tick(1'b0, 1'b0, 1'b0, "post_rst");
    check("post_rst_air", 32'(airborne), 32'd0);
    do_tick(1'b0, 1'b0, 1'b1, "post_rst_jump");
    check("post_rst_jump", 32'(airborne), 32'd1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
